// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared definitions for the two-requester shift-add multiplier.
//   OP_W     operand width
//   PROD_W   product / accumulator width
//   NUM_ITER number of shift-add iterations per job
//   CNT_W    width of the iteration counter
//   state_t  arbiter FSM states
package mult_arb_pkg;

  localparam int unsigned OP_W     = 8;
  localparam int unsigned PROD_W   = 16;
  localparam int unsigned NUM_ITER = 8;
  localparam int unsigned CNT_W    = $clog2(NUM_ITER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_core.sv
// shift_add_core: iterative shift-add multiplier datapath.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   load      capture a/b, clear accumulator and counter
//   step      perform one iteration (add a<<k if b[k])
//   a, b      operands (sampled on load only)
//   sum       accumulator value after the current step
//   done      high during the step that completes the last iteration
module shift_add_core
  import mult_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] sum,
  output logic              done
);

  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] a_sh;
  logic [OP_W-1:0]   b_q;
  logic [CNT_W-1:0]  cnt;

  // sum is the post-step accumulator so the final product is available
  // combinationally in the same cycle as done.
  always_comb begin
    sum  = acc + (b_q[cnt] ? a_sh : '0);
    done = step && (cnt == CNT_W'(NUM_ITER - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      a_sh <= '0;
      b_q  <= '0;
      cnt  <= '0;
    end else if (load) begin
      acc  <= '0;
      a_sh <= PROD_W'(a);
      b_q  <= b;
      cnt  <= '0;
    end else if (step) begin
      acc  <= sum;
      a_sh <= a_sh << 1;
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: arbitrates two requesters onto one shift-add multiplier.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_reqN, i_aN, i_bN    requester N request level and operands
//   o_gntN                one-cycle pulse: requester N operands captured
//   o_doneN               one-cycle pulse: requester N result on o_p
//   o_p                   product of the last completed job
//   o_busy                a job is in progress
// Configuration:
//   MULT_ARB_ROUND_ROBIN_EN  defined: simultaneous requests alternate via a
//                            last-served pointer; undefined: requester 0 wins.
module mult_arbiter
  import mult_arb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic [OP_W-1:0]   i_a0,
  input  logic [OP_W-1:0]   i_b0,
  input  logic              i_req1,
  input  logic [OP_W-1:0]   i_a1,
  input  logic [OP_W-1:0]   i_b1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_done0,
  output logic              o_done1,
  output logic [PROD_W-1:0] o_p,
  output logic              o_busy
);

  state_t            state, state_nxt;
  logic              sel;
  logic              win1;
  logic              core_load;
  logic              core_step;
  logic              core_done;
  logic [PROD_W-1:0] core_sum;
  logic [OP_W-1:0]   a_mux;
  logic [OP_W-1:0]   b_mux;

`ifdef MULT_ARB_ROUND_ROBIN_EN
  logic last_q;
  // On a tie, requester 1 wins only if requester 0 was served last.
  assign win1 = i_req1 & (~i_req0 | ~last_q);
`else
  assign win1 = i_req1 & ~i_req0;
`endif

  assign a_mux = win1 ? i_a1 : i_a0;
  assign b_mux = win1 ? i_b1 : i_b0;

  shift_add_core u_core (
    .clk  (i_clk),
    .rst  (i_rst),
    .load (core_load),
    .step (core_step),
    .a    (a_mux),
    .b    (b_mux),
    .sum  (core_sum),
    .done (core_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          core_load = 1'b1;
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        core_step = 1'b1;
        if (core_done) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel    <= 1'b0;
      o_gnt0 <= 1'b0;
      o_gnt1 <= 1'b0;
      o_p    <= '0;
`ifdef MULT_ARB_ROUND_ROBIN_EN
      last_q <= 1'b1;
`endif
    end else begin
      o_gnt0 <= core_load & ~win1;
      o_gnt1 <= core_load & win1;
      if (core_load) begin
        sel <= win1;
`ifdef MULT_ARB_ROUND_ROBIN_EN
        last_q <= win1;
`endif
      end
      if (core_done) o_p <= core_sum;
    end
  end

  assign o_done0 = (state == ST_DONE) && !sel;
  assign o_done1 = (state == ST_DONE) && sel;
  assign o_busy  = (state != ST_IDLE);

endmodule
